// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with start/done handshake.
// Define MULDIV_SIGNED_EN to honour op_signed (magnitude in, sign fix-up out).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: start is taken only in IDLE/DONE; while busy it is dropped, not queued.
  // done is a one-cycle pulse and hi/lo/div_by_zero are already valid in that cycle.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d, work_lo_q, work_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             op_q, op_d, dbz_q, dbz_d;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo, a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  logic             neg_q, neg_d, rneg_q, rneg_d;
  logic             a_neg, b_neg;
  logic [2*WIDTH-1:0] prod;
`else
  logic unused_op_signed;
  assign unused_op_signed = op_signed;
`endif

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : '0)};
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    div_ge    = ~div_diff[WIDTH];
    if (op_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {work_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
`ifdef MULDIV_SIGNED_EN
    a_neg = op_signed & a[WIDTH-1];
    b_neg = op_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    prod  = {step_hi, step_lo};
    if (op_q) begin
      res_hi = rneg_q ? -step_hi : step_hi;
      res_lo = neg_q  ? -step_lo : step_lo;
    end else begin
      prod   = neg_q ? -prod : prod;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
`else
    a_mag  = a;
    b_mag  = b;
    res_hi = step_hi;
    res_lo = step_lo;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
`ifdef MULDIV_SIGNED_EN
    neg_d     = neg_q;
    rneg_d    = rneg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (op && (b == '0)) begin
            state_d = S_DONE;
            hi_d    = a;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d   = S_RUN;
            cnt_d     = CNT_W'(WIDTH);
            dbz_d     = 1'b0;
            op_d      = op;
            work_hi_d = '0;
            work_lo_d = op ? a_mag : b_mag;
            opnd_d    = op ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
`endif
          end
        end
      end
      S_RUN: begin
        work_hi_d = step_hi;
        work_lo_d = step_lo;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      op_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32); signed expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk, reset, start, op, op_signed;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_by_zero;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_signed(op_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Call right after a negedge. lat = cycles from start edge to the done cycle (-1 on timeout).
  task automatic run_op(input logic o, input logic s, input logic [W-1:0] va,
                        input logic [W-1:0] vb, output int lat, output int bcnt);
    op = o; op_signed = s; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 1'b0; op_signed = 1'b0; a = '0; b = '0;
    #12;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== '0)            begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== '0)            begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int lat, bc;
    logic [W-1:0] e_hi [4];
    logic [W-1:0] e_lo [4];
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         sg [4];
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; sg[0] = 0; e_hi[0] = 32'hFFFFFFFE; e_lo[0] = 32'h1;
    va[1] = 32'h00010000; vb[1] = 32'h00010000; sg[1] = 0; e_hi[1] = 32'h1;        e_lo[1] = 32'h0;
    va[2] = 32'h0;        vb[2] = 32'h12345678; sg[2] = 0; e_hi[2] = 32'h0;        e_lo[2] = 32'h0;
    va[3] = 32'hFFFFFFFD; vb[3] = 32'h5;        sg[3] = 1;
`ifdef MULDIV_SIGNED_EN
    e_hi[3] = 32'hFFFFFFFF; e_lo[3] = 32'hFFFFFFF1;
`else
    e_hi[3] = 32'h4;        e_lo[3] = 32'hFFFFFFF1;
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, sg[i], va[i], vb[i], lat, bc);
      total++; if (lat !== 33)      begin bad++; $display("FAIL mult%0d_latency got=%0d exp=33", i, lat); end
      total++; if (bc !== 32)       begin bad++; $display("FAIL mult%0d_busy_cycles got=%0d exp=32", i, bc); end
      total++; if (hi !== e_hi[i])  begin bad++; $display("FAIL mult%0d_hi got=%h exp=%h", i, hi, e_hi[i]); end
      total++; if (lo !== e_lo[i])  begin bad++; $display("FAIL mult%0d_lo got=%h exp=%h", i, lo, e_lo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_div;
    int lat, bc;
    logic [W-1:0] e_hi [5];
    logic [W-1:0] e_lo [5];
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         sg [5];
    va[0] = 32'd100;      vb[0] = 32'd7;        sg[0] = 0; e_lo[0] = 32'd14;       e_hi[0] = 32'd2;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'h10;       sg[1] = 0; e_lo[1] = 32'h0FFFFFFF; e_hi[1] = 32'hF;
    va[2] = 32'hFFFFFFF9; vb[2] = 32'd2;        sg[2] = 1;
    va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF; sg[3] = 1;
    va[4] = 32'd7;        vb[4] = 32'hFFFFFFFE; sg[4] = 1;
`ifdef MULDIV_SIGNED_EN
    e_lo[2] = 32'hFFFFFFFD; e_hi[2] = 32'hFFFFFFFF;
    e_lo[3] = 32'h80000000; e_hi[3] = 32'h0;
    e_lo[4] = 32'hFFFFFFFD; e_hi[4] = 32'd1;
`else
    e_lo[2] = 32'h7FFFFFFC; e_hi[2] = 32'd1;
    e_lo[3] = 32'h0;        e_hi[3] = 32'h80000000;
    e_lo[4] = 32'h0;        e_hi[4] = 32'd7;
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, sg[i], va[i], vb[i], lat, bc);
      total++; if (lat !== 33)             begin bad++; $display("FAIL div%0d_latency got=%0d exp=33", i, lat); end
      total++; if (lo !== e_lo[i])         begin bad++; $display("FAIL div%0d_lo got=%h exp=%h", i, lo, e_lo[i]); end
      total++; if (hi !== e_hi[i])         begin bad++; $display("FAIL div%0d_hi got=%h exp=%h", i, hi, e_hi[i]); end
      total++; if (div_by_zero !== 1'b0)   begin bad++; $display("FAIL div%0d_dbz got=%b exp=0", i, div_by_zero); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero;
    int lat, bc;
    run_op(1'b1, 1'b0, 32'h1234, 32'h0, lat, bc);
    total++; if (lat !== 1)              begin bad++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    total++; if (bc !== 0)               begin bad++; $display("FAIL dbz_busy_cycles got=%0d exp=0", bc); end
    total++; if (hi !== 32'h1234)        begin bad++; $display("FAIL dbz_hi got=%h exp=00001234", hi); end
    total++; if (lo !== 32'hFFFFFFFF)    begin bad++; $display("FAIL dbz_lo got=%h exp=ffffffff", lo); end
    total++; if (div_by_zero !== 1'b1)   begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    @(negedge clk);
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'h0, lat, bc);
    total++; if (lat !== 1)              begin bad++; $display("FAIL sdbz_latency got=%0d exp=1", lat); end
    total++; if (hi !== 32'hFFFFFFF9)    begin bad++; $display("FAIL sdbz_hi got=%h exp=fffffff9", hi); end
    total++; if (lo !== 32'hFFFFFFFF)    begin bad++; $display("FAIL sdbz_lo got=%h exp=ffffffff", lo); end
    @(negedge clk);
  endtask

  // Starts 10/3 just after a div-by-zero result; checks hold during RUN, ignored start, frozen b.
  task automatic test_ignored_start;
    int ndone, first_done, holds_bad;
    logic [W-1:0] hold_hi, hold_lo;
    hold_hi = hi; hold_lo = lo;
    ndone = 0; first_done = -1; holds_bad = 0;
    op = 1'b1; op_signed = 1'b0; a = 32'd10; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (busy && (hi !== hold_hi || lo !== hold_lo || div_by_zero !== 1'b0)) holds_bad++;
      if (done) begin ndone++; if (first_done < 0) first_done = n; end
      if (n == 5)  begin a = 32'd99; start = 1'b1; end
      if (n == 6)  start = 1'b0;
      if (n == 10) b = 32'd7;
    end
    total++; if (ndone !== 1)       begin bad++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    total++; if (first_done !== 33) begin bad++; $display("FAIL ign_latency got=%0d exp=33", first_done); end
    total++; if (holds_bad !== 0)   begin bad++; $display("FAIL ign_hold_during_run got=%0d exp=0", holds_bad); end
    total++; if (lo !== 32'd3)      begin bad++; $display("FAIL ign_lo got=%h exp=3", lo); end
    total++; if (hi !== 32'd1)      begin bad++; $display("FAIL ign_hi got=%h exp=1", hi); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    run_op(1'b0, 1'b0, 32'd3, 32'd5, lat, bc);
    total++; if (lo !== 32'd15) begin bad++; $display("FAIL b2b_first_lo got=%h exp=f", lo); end
    run_op(1'b0, 1'b0, 32'd6, 32'd7, lat, bc);
    total++; if (lat !== 33)    begin bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    total++; if (lo !== 32'd42) begin bad++; $display("FAIL b2b_lo got=%h exp=2a", lo); end
    total++; if (hi !== 32'd0)  begin bad++; $display("FAIL b2b_hi got=%h exp=0", hi); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int lat, bc;
    op = 1'b0; op_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_run_busy_before got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_run_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_run_done got=%b exp=0", done); end
    total++; if (hi !== '0)            begin bad++; $display("FAIL rst_run_hi got=%h exp=0", hi); end
    total++; if (lo !== '0)            begin bad++; $display("FAIL rst_run_lo got=%h exp=0", lo); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_run_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    total++; if (lat !== 33)          begin bad++; $display("FAIL rst_after_latency got=%0d exp=33", lat); end
    total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL rst_after_hi got=%h exp=fffffffe", hi); end
    total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL rst_after_lo got=%h exp=1", lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_by_zero;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
